// File: rtl/instr_encode_if.sv
// Descriptor-in / machine-word-out bus of the instruction encoder.
// The master drives descriptors and accepts words; the slave is the encoder itself.
`timescale 1ns/1ps
interface instr_encode_if #(
  parameter int unsigned ADDR_W = 6
) ();
  logic              in_valid;
  logic              in_ready;
  logic [1:0]        in_cls;
  logic              in_imm_sel;
  logic [3:0]        in_cmd;
  logic              in_s;
  logic              in_load;
  logic              in_byte;
  logic [3:0]        in_cond;
  logic [3:0]        in_rd;
  logic [3:0]        in_rn;
  logic [3:0]        in_rm;
  logic [31:0]       in_imm;
  logic              out_valid;
  logic              out_ready;
  logic [31:0]       out_instr;
  logic [ADDR_W-1:0] out_addr;

  modport master (
    output in_valid, in_cls, in_imm_sel, in_cmd, in_s, in_load, in_byte, in_cond,
    output in_rd, in_rn, in_rm, in_imm, out_ready,
    input  in_ready, out_valid, out_instr, out_addr
  );

  modport slave (
    input  in_valid, in_cls, in_imm_sel, in_cmd, in_s, in_load, in_byte, in_cond,
    input  in_rd, in_rn, in_rm, in_imm, out_ready,
    output in_ready, out_valid, out_instr, out_addr
  );
endinterface

// File: rtl/instr_encode.sv
// Sequential encoder of decoded descriptors into 32-bit ARM words (DP, LDR/STR[B], B),
// with a one-rotation-per-cycle search for DP immediates and sequential word addressing.
`timescale 1ns/1ps
module instr_encode #(
  parameter int unsigned ADDR_W     = 6,
  parameter int unsigned START_ADDR = 0
) (
  input  logic           clk,
  input  logic           reset,
  instr_encode_if.slave  bus,
  output logic           err,
  output logic           err_sticky
);

  typedef enum logic [1:0] {StIdle, StSearch, StOut} state_e;

  state_e            state_q, state_d;
  logic [31:0]       out_instr_q, out_instr_d;
  logic [ADDR_W-1:0] out_addr_q, out_addr_d;
  logic              err_q, err_d;
  logic              err_sticky_q, err_sticky_d;
  logic [3:0]        rot_q, rot_d;
  logic [31:0]       imm_q, imm_d;
  logic [19:0]       hdr_q, hdr_d;

  logic        accept;
  logic        mem_err;
  logic        br_err;
  logic [32:0] br_off;
  logic [32:0] br_sh;
  logic [63:0] rot_dbl;
  logic [31:0] rot_val;

  assign accept = bus.in_valid && (state_q == StIdle);

  // Sign-extend to 33 bits so the -8 bias cannot wrap for extreme offsets.
  assign br_off  = {bus.in_imm[31], bus.in_imm} - 33'd8;
  assign br_sh   = $signed(br_off) >>> 2;
  assign br_err  = (|bus.in_imm[1:0]) || !((&br_sh[32:23]) || !(|br_sh[32:23]));
  assign mem_err = |bus.in_imm[31:12];

  // Upper half of the doubled word shifted left is the word rotated left by 2r.
  assign rot_dbl = {imm_q, imm_q} << {rot_q, 1'b0};
  assign rot_val = rot_dbl[63:32];

  always_comb begin
    state_d      = state_q;
    out_instr_d  = out_instr_q;
    out_addr_d   = out_addr_q;
    err_d        = 1'b0;
    rot_d        = rot_q;
    imm_d        = imm_q;
    hdr_d        = hdr_q;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          unique case (bus.in_cls)
            2'd0: begin
              if (bus.in_imm_sel) begin
                hdr_d   = {bus.in_cond, 2'b00, 1'b1, bus.in_cmd, bus.in_s, bus.in_rn, bus.in_rd};
                imm_d   = bus.in_imm;
                rot_d   = 4'd0;
                state_d = StSearch;
              end else begin
                out_instr_d = {bus.in_cond, 3'b000, bus.in_cmd, bus.in_s, bus.in_rn,
                               bus.in_rd, 8'h00, bus.in_rm};
                state_d     = StOut;
              end
            end
            2'd1: begin
              if (mem_err) begin
                err_d = 1'b1;
              end else begin
                out_instr_d = {bus.in_cond, 2'b01, 3'b011, bus.in_byte, 1'b0, bus.in_load,
                               bus.in_rn, bus.in_rd, bus.in_imm[11:0]};
                state_d     = StOut;
              end
            end
            2'd2: begin
              if (br_err) begin
                err_d = 1'b1;
              end else begin
                out_instr_d = {bus.in_cond, 4'b1010, br_sh[23:0]};
                state_d     = StOut;
              end
            end
            2'd3: err_d = 1'b1;
          endcase
        end
      end
      StSearch: begin
        if (rot_val[31:8] == 24'd0) begin
          out_instr_d = {hdr_q, rot_q, rot_val[7:0]};
          state_d     = StOut;
        end else if (rot_q == 4'd15) begin
          err_d   = 1'b1;
          rot_d   = 4'd0;
          state_d = StIdle;
        end else begin
          rot_d = rot_q + 4'd1;
        end
      end
      StOut: begin
        if (bus.out_ready) begin
          out_addr_d = out_addr_q + 1'b1;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    err_sticky_d = err_sticky_q || err_d;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= StIdle;
      out_instr_q  <= 32'd0;
      out_addr_q   <= ADDR_W'(START_ADDR);
      err_q        <= 1'b0;
      err_sticky_q <= 1'b0;
      rot_q        <= 4'd0;
      imm_q        <= 32'd0;
      hdr_q        <= 20'd0;
    end else begin
      state_q      <= state_d;
      out_instr_q  <= out_instr_d;
      out_addr_q   <= out_addr_d;
      err_q        <= err_d;
      err_sticky_q <= err_sticky_d;
      rot_q        <= rot_d;
      imm_q        <= imm_d;
      hdr_q        <= hdr_d;
    end
  end

  assign bus.in_ready  = (state_q == StIdle);
  assign bus.out_valid = (state_q == StOut);
  assign bus.out_instr = out_instr_q;
  assign bus.out_addr  = out_addr_q;
  assign err           = err_q;
  assign err_sticky    = err_sticky_q;

endmodule

// File: tb/tb_instr_encode.sv
// Directed bench for instr_encode: encodings, search latency, errors, back-pressure,
// address wrap and asynchronous reset.
`timescale 1ns/1ps
module tb_instr_encode;

  logic clk;
  logic reset;
  logic err, err_sticky;
  logic err_w, err_sticky_w;
  int   checks;
  int   errors;

  instr_encode_if #(.ADDR_W(6)) bus ();
  instr_encode_if #(.ADDR_W(6)) bus_w ();

  instr_encode #(.ADDR_W(6), .START_ADDR(0)) u_dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus),
    .err        (err),
    .err_sticky (err_sticky)
  );

  instr_encode #(.ADDR_W(6), .START_ADDR(63)) u_dut_wrap (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus_w),
    .err        (err_w),
    .err_sticky (err_sticky_w)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drive one descriptor for a single accept edge; returns #1 after that edge.
  task automatic send(input logic [1:0] cls, input logic imm_sel, input logic [3:0] cmd,
                      input logic s, input logic load, input logic byt, input logic [3:0] cond,
                      input logic [3:0] rd, input logic [3:0] rn, input logic [3:0] rm,
                      input logic [31:0] imm);
    bus.in_cls     = cls;
    bus.in_imm_sel = imm_sel;
    bus.in_cmd     = cmd;
    bus.in_s       = s;
    bus.in_load    = load;
    bus.in_byte    = byt;
    bus.in_cond    = cond;
    bus.in_rd      = rd;
    bus.in_rn      = rn;
    bus.in_rm      = rm;
    bus.in_imm     = imm;
    bus.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus.in_valid   = 1'b0;
  endtask

  // Cycles from accept edge until out_valid, bounded.
  task automatic wait_valid(output int lat);
    lat = 1;
    while (!bus.out_valid && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
  endtask

  task automatic handshake();
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_hs: in_ready=%b out_valid=%b required 1/0", bus.in_ready,
               bus.out_valid);
    end
    checks++;
    if (bus.out_instr !== 32'd0 || bus.out_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_out: instr=%h addr=%0d required 0/0", bus.out_instr, bus.out_addr);
    end
    checks++;
    if (err !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_err: err=%b sticky=%b required 0/0", err, err_sticky);
    end
    checks++;
    if (bus_w.out_addr !== 6'd63) begin
      errors++;
      $display("FAIL reset_start_addr: addr=%0d required 63", bus_w.out_addr);
    end
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_dp_reg();
    send(2'd0, 1'b0, 4'b0100, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd3, 32'd0);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE0821003 || bus.out_addr !== 6'd0) begin
      errors++;
      $display("FAIL dp_reg: valid=%b instr=%h addr=%0d required 1/E0821003/0",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    checks++;
    if (bus.in_ready !== 1'b0) begin
      errors++;
      $display("FAIL dp_reg_in_ready: got %b required 0", bus.in_ready);
    end
    handshake();
    checks++;
    if (bus.out_addr !== 6'd1 || bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL dp_reg_hs: addr=%0d valid=%b in_ready=%b required 1/0/1",
               bus.out_addr, bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_dp_imm();
    int  lat;
    logic saw_valid;
    send(2'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd0, 32'hFF000000);
    wait_valid(lat);
    checks++;
    if (lat != 6 || bus.out_instr !== 32'hE29214FF) begin
      errors++;
      $display("FAIL dp_imm_rot4: lat=%0d instr=%h required 6/E29214FF", lat, bus.out_instr);
    end
    handshake();
    send(2'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd0, 32'h000000FF);
    wait_valid(lat);
    checks++;
    if (lat != 2 || bus.out_instr !== 32'hE29210FF) begin
      errors++;
      $display("FAIL dp_imm_rot0: lat=%0d instr=%h required 2/E29210FF", lat, bus.out_instr);
    end
    handshake();
    send(2'd0, 1'b1, 4'b0100, 1'b1, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd0, 32'h00000101);
    lat = 1;
    saw_valid = 1'b0;
    while (!err && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
      saw_valid = saw_valid | bus.out_valid;
    end
    checks++;
    if (lat != 17 || err_sticky !== 1'b1 || saw_valid !== 1'b0) begin
      errors++;
      $display("FAIL dp_imm_unfit: lat=%0d sticky=%b saw_valid=%b required 17/1/0",
               lat, err_sticky, saw_valid);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_addr !== 6'd3) begin
      errors++;
      $display("FAIL dp_imm_unfit_after: err=%b in_ready=%b addr=%0d required 0/1/3",
               err, bus.in_ready, bus.out_addr);
    end
  endtask

  task automatic test_mem();
    send(2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'hE, 4'd0, 4'd1, 4'd0, 32'd8);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE5910008 || bus.out_addr !== 6'd3) begin
      errors++;
      $display("FAIL mem_ldr: valid=%b instr=%h addr=%0d required 1/E5910008/3",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    handshake();
    send(2'd1, 1'b0, 4'd0, 1'b0, 1'b0, 1'b1, 4'hE, 4'd2, 4'd3, 4'd0, 32'd4);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE5C32004 || bus.out_addr !== 6'd4) begin
      errors++;
      $display("FAIL mem_strb: valid=%b instr=%h addr=%0d required 1/E5C32004/4",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    handshake();
    send(2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'hE, 4'd0, 4'd1, 4'd0, 32'd4096);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 6'd5) begin
      errors++;
      $display("FAIL mem_range: err=%b valid=%b addr=%0d required 1/0/5",
               err, bus.out_valid, bus.out_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (err !== 1'b0 || bus.out_addr !== 6'd5) begin
      errors++;
      $display("FAIL mem_range_pulse: err=%b addr=%0d required 0/5", err, bus.out_addr);
    end
  endtask

  task automatic test_branch();
    send(2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 32'd16);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hEA000002) begin
      errors++;
      $display("FAIL br_fwd: valid=%b instr=%h required 1/EA000002", bus.out_valid,
               bus.out_instr);
    end
    handshake();
    send(2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 32'hFFFFFFF8);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hEAFFFFFC || bus.out_addr !== 6'd6) begin
      errors++;
      $display("FAIL br_back: valid=%b instr=%h addr=%0d required 1/EAFFFFFC/6",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    handshake();
    send(2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 32'd6);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 6'd7) begin
      errors++;
      $display("FAIL br_align: err=%b valid=%b addr=%0d required 1/0/7",
               err, bus.out_valid, bus.out_addr);
    end
    send(2'd2, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 32'h02000008);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL br_range: err=%b valid=%b required 1/0", err, bus.out_valid);
    end
    send(2'd3, 1'b0, 4'd0, 1'b0, 1'b0, 1'b0, 4'hE, 4'd0, 4'd0, 4'd0, 32'd0);
    checks++;
    if (err !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 6'd7) begin
      errors++;
      $display("FAIL illegal_cls: err=%b valid=%b addr=%0d required 1/0/7",
               err, bus.out_valid, bus.out_addr);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_backpressure();
    send(2'd0, 1'b0, 4'b0001, 1'b1, 1'b0, 1'b0, 4'h0, 4'd4, 4'd5, 4'd6, 32'd0);
    for (int i = 0; i < 5; i++) begin
      checks++;
      if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'h00354006 || bus.out_addr !== 6'd7 ||
          bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL backpressure[%0d]: valid=%b instr=%h addr=%0d in_ready=%b req 1/00354006/7/0",
                 i, bus.out_valid, bus.out_instr, bus.out_addr, bus.in_ready);
      end
      @(posedge clk);
      #1;
    end
    handshake();
    checks++;
    if (bus.out_addr !== 6'd8 || bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_hs: addr=%0d valid=%b required 8/0", bus.out_addr,
               bus.out_valid);
    end
  endtask

  task automatic test_back_to_back();
    bus.out_ready = 1'b1;
    send(2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'hE, 4'd0, 4'd1, 4'd0, 32'd8);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_addr !== 6'd8) begin
      errors++;
      $display("FAIL b2b_out: valid=%b addr=%0d required 1/8", bus.out_valid, bus.out_addr);
    end
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1 || bus.out_addr !== 6'd9) begin
      errors++;
      $display("FAIL b2b_idle: valid=%b in_ready=%b addr=%0d required 0/1/9",
               bus.out_valid, bus.in_ready, bus.out_addr);
    end
    bus.out_ready = 1'b0;
  endtask

  task automatic test_wrap();
    bus_w.in_cls     = 2'd0;
    bus_w.in_imm_sel = 1'b0;
    bus_w.in_cmd     = 4'b0100;
    bus_w.in_s       = 1'b0;
    bus_w.in_cond    = 4'hE;
    bus_w.in_rd      = 4'd1;
    bus_w.in_rn      = 4'd2;
    bus_w.in_rm      = 4'd3;
    bus_w.in_valid   = 1'b1;
    @(posedge clk);
    #1;
    bus_w.in_valid   = 1'b0;
    checks++;
    if (bus_w.out_valid !== 1'b1 || bus_w.out_addr !== 6'd63 ||
        bus_w.out_instr !== 32'hE0821003) begin
      errors++;
      $display("FAIL wrap_out: valid=%b addr=%0d instr=%h required 1/63/E0821003",
               bus_w.out_valid, bus_w.out_addr, bus_w.out_instr);
    end
    bus_w.out_ready = 1'b1;
    @(posedge clk);
    #1;
    bus_w.out_ready = 1'b0;
    checks++;
    if (bus_w.out_addr !== 6'd0) begin
      errors++;
      $display("FAIL wrap_addr: addr=%0d required 0", bus_w.out_addr);
    end
  endtask

  task automatic test_reset_mid_search();
    send(2'd0, 1'b1, 4'b0100, 1'b0, 1'b0, 1'b0, 4'hE, 4'd1, 4'd2, 4'd0, 32'h00000101);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    checks++;
    if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0 || bus.out_addr !== 6'd0 ||
        bus.out_instr !== 32'd0 || err !== 1'b0 || err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL reset_async: rdy=%b vld=%b addr=%0d instr=%h err=%b sticky=%b req 1/0/0/0/0/0",
               bus.in_ready, bus.out_valid, bus.out_addr, bus.out_instr, err, err_sticky);
    end
    @(posedge clk);
    #3;
    reset = 1'b1;
    @(posedge clk);
    #1;
    send(2'd1, 1'b0, 4'd0, 1'b0, 1'b1, 1'b0, 4'hE, 4'd0, 4'd1, 4'd0, 32'd8);
    checks++;
    if (bus.out_valid !== 1'b1 || bus.out_instr !== 32'hE5910008 || bus.out_addr !== 6'd0) begin
      errors++;
      $display("FAIL reset_resume: valid=%b instr=%h addr=%0d required 1/E5910008/0",
               bus.out_valid, bus.out_instr, bus.out_addr);
    end
    handshake();
  endtask

  initial begin
    checks          = 0;
    errors          = 0;
    bus.in_valid    = 1'b0;
    bus.in_cls      = 2'd0;
    bus.in_imm_sel  = 1'b0;
    bus.in_cmd      = 4'd0;
    bus.in_s        = 1'b0;
    bus.in_load     = 1'b0;
    bus.in_byte     = 1'b0;
    bus.in_cond     = 4'd0;
    bus.in_rd       = 4'd0;
    bus.in_rn       = 4'd0;
    bus.in_rm       = 4'd0;
    bus.in_imm      = 32'd0;
    bus.out_ready   = 1'b0;
    bus_w.in_valid  = 1'b0;
    bus_w.in_cls    = 2'd0;
    bus_w.in_imm_sel = 1'b0;
    bus_w.in_cmd    = 4'd0;
    bus_w.in_s      = 1'b0;
    bus_w.in_load   = 1'b0;
    bus_w.in_byte   = 1'b0;
    bus_w.in_cond   = 4'd0;
    bus_w.in_rd     = 4'd0;
    bus_w.in_rn     = 4'd0;
    bus_w.in_rm     = 4'd0;
    bus_w.in_imm    = 32'd0;
    bus_w.out_ready = 1'b0;

    test_reset();
    test_dp_reg();
    test_dp_imm();
    test_mem();
    test_branch();
    test_backpressure();
    test_back_to_back();
    test_wrap();
    test_reset_mid_search();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
